// File: rtl/mips_md_pkg.sv
// Shared multiply/divide op codes and predicates.
// Used by the MD issue controller, the MD unit and the decoder.
package mips_md_pkg;

    localparam int unsigned OP_W = 3;

    typedef logic [OP_W-1:0] md_op_t;

    localparam md_op_t MD_NONE  = 3'd0;
    localparam md_op_t MD_MULT  = 3'd1;
    localparam md_op_t MD_MULTU = 3'd2;
    localparam md_op_t MD_DIV   = 3'd3;
    localparam md_op_t MD_DIVU  = 3'd4;
    localparam md_op_t MD_MTLO  = 3'd5;
    localparam md_op_t MD_MTHI  = 3'd6;

    // Any op that the MD unit accepts as a command.
    function automatic logic is_md_op(input md_op_t op);
        return (op >= MD_MULT) && (op <= MD_MTHI);
    endfunction

    // Ops that start a multi-cycle countdown in the unit.
    function automatic logic is_muldiv(input md_op_t op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    function automatic logic is_mul(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    function automatic logic is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Direct HI/LO writes; these need a rollback rather than a cancel.
    function automatic logic is_mt(input md_op_t op);
        return (op == MD_MTLO) || (op == MD_MTHI);
    endfunction

endpackage

// File: rtl/md_busy_shadow.sv
// Registered shadow of the MD unit's busy window plus a sticky divergence flag.
// Ports:
//   clk, reset        clock, async active-high reset
//   break_md          cancel in flight: clears the countdown
//   issue, op         op being issued to the unit this cycle
//   md_busy           Busy reported by the unit
//   shadow_busy       predicted Busy (combinational, issue cycle included)
//   busy_mismatch     sticky: shadow_busy disagreed with md_busy on some edge
module md_busy_shadow
    import mips_md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   break_md,
    input  logic   issue,
    input  md_op_t op,
    input  logic   md_busy,
    output logic   shadow_busy,
    output logic   busy_mismatch
);

    logic [CNT_W-1:0] cnt;

    // Countdown of remaining busy cycles after the issue cycle; runs through pipe holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (break_md) begin
            cnt <= '0;
        end else if (issue && is_mul(op)) begin
            cnt <= CNT_W'(MULT_CYCLES - 1);
        end else if (issue && is_div(op)) begin
            cnt <= CNT_W'(DIV_CYCLES - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // The unit raises Busy in the issue cycle itself, so include the issuing op.
    assign shadow_busy = (cnt != '0) | (issue & is_muldiv(op));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_mismatch <= 1'b0;
        end else if (md_busy != shadow_busy) begin
            busy_mismatch <= 1'b1;
        end
    end

endmodule

// File: rtl/md_issue_ctrl.sv
// Pipeline-side issue controller for the multiply/divide unit.
// Ports:
//   clk, reset      clock, async active-high reset
//   d_md_use        D holds an MD instruction (incl. mfhi/mflo)
//   e_md_op         MD op of the instruction in E
//   e_valid         E holds a real instruction
//   pipe_hold       pipeline frozen this cycle
//   exc_flush       exception taken; M and younger are killed
//   md_busy         Busy from the MD unit
//   md_ctr          command to the MD unit (combinational)
//   break_md        cancel in-flight mult/div (combinational)
//   return_lohi     restore previous HI/LO (combinational)
//   stall_d         hold D, bubble into E (combinational)
//   busy_mismatch   sticky shadow/unit Busy divergence (registered)
module md_issue_ctrl
    import mips_md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         d_md_use,
    input  logic [2:0]   e_md_op,
    input  logic         e_valid,
    input  logic         pipe_hold,
    input  logic         exc_flush,
    input  logic         md_busy,
    output logic [2:0]   md_ctr,
    output logic         break_md,
    output logic         return_lohi,
    output logic         stall_d,
    output logic         busy_mismatch
);

    logic   issue;
    logic   shadow_busy;
    md_op_t m_op_q;

    // An exception in this cycle kills the E op before it reaches the unit.
    assign issue  = e_valid & ~pipe_hold & ~exc_flush & is_md_op(e_md_op);
    assign md_ctr = issue ? e_md_op : MD_NONE;

    // Op that reached the unit last cycle, i.e. the MD op now sitting in M.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_op_q <= MD_NONE;
        end else if (exc_flush) begin
            m_op_q <= MD_NONE;
        end else if (!pipe_hold) begin
            m_op_q <= issue ? e_md_op : MD_NONE;
        end
    end

    // Undo the killed M op: cancel a countdown or roll back a HI/LO write.
    assign break_md    = exc_flush & is_muldiv(m_op_q);
    assign return_lohi = exc_flush & is_mt(m_op_q);

    assign stall_d = d_md_use & shadow_busy;

    md_busy_shadow #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_shadow (
        .clk           (clk),
        .reset         (reset),
        .break_md      (break_md),
        .issue         (issue),
        .op            (e_md_op),
        .md_busy       (md_busy),
        .shadow_busy   (shadow_busy),
        .busy_mismatch (busy_mismatch)
    );

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed scenarios then random traffic,
// against a timestamp-based model of the MD unit's busy window.
module tb_md_issue_ctrl;

    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_md_use;
    logic [2:0] e_md_op;
    logic       e_valid;
    logic       pipe_hold;
    logic       exc_flush;
    logic       md_busy;
    logic [2:0] md_ctr;
    logic       break_md;
    logic       return_lohi;
    logic       stall_d;
    logic       busy_mismatch;

    md_issue_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .d_md_use      (d_md_use),
        .e_md_op       (e_md_op),
        .e_valid       (e_valid),
        .pipe_hold     (pipe_hold),
        .exc_flush     (exc_flush),
        .md_busy       (md_busy),
        .md_ctr        (md_ctr),
        .break_md      (break_md),
        .return_lohi   (return_lohi),
        .stall_d       (stall_d),
        .busy_mismatch (busy_mismatch)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: unit busy through cycle busy_until (inclusive); op now in M.
    int         cyc;
    int         busy_until;
    logic [2:0] m_op;
    logic       exp_mism;
    int         stall_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic op_is_cmd(input logic [2:0] op);
        return op >= 3'd1 && op <= 3'd6;
    endfunction

    function automatic logic op_is_long(input logic [2:0] op);
        return op >= 3'd1 && op <= 3'd4;
    endfunction

    task automatic model_reset();
        busy_until = -1;
        m_op       = 3'd0;
        exp_mism   = 1'b0;
    endtask

    // One clock cycle, entered just after a falling edge.
    task automatic step(input logic v, input logic [2:0] op, input logic du,
                        input logic hold, input logic flush, input logic force_idle);
        logic       iss, ebusy, ebrk, eret, estall;
        logic [2:0] ectr;
        int         ecnt;
        e_valid   = v;
        e_md_op   = op;
        d_md_use  = du;
        pipe_hold = hold;
        exc_flush = flush;
        iss    = v && !hold && !flush && op_is_cmd(op);
        ectr   = iss ? op : 3'd0;
        ebrk   = flush && op_is_long(m_op);
        eret   = flush && (m_op == 3'd5 || m_op == 3'd6);
        ebusy  = (busy_until >= cyc) || (iss && op_is_long(op));
        estall = du && ebusy;
        ecnt   = (busy_until >= cyc) ? busy_until - cyc + 1 : 0;
        md_busy = force_idle ? 1'b0 : ebusy;
        #1;
        chk("md_ctr", 32'(md_ctr), 32'(ectr));
        chk("break_md", 32'(break_md), 32'(ebrk));
        chk("return_lohi", 32'(return_lohi), 32'(eret));
        chk("stall_d", 32'(stall_d), 32'(estall));
        chk("busy_mismatch", 32'(busy_mismatch), 32'(exp_mism));
        chk("shadow_cnt", 32'(dut.u_shadow.cnt), 32'(ecnt));
        chk("m_op_q", 32'(dut.m_op_q), 32'(m_op));
        if (stall_d) stall_seen++;
        @(posedge clk);
        if (md_busy != ebusy) exp_mism = 1'b1;
        if (flush)      m_op = 3'd0;
        else if (!hold) m_op = iss ? op : 3'd0;
        if (ebrk)                              busy_until = cyc;
        else if (iss && (op == 3'd1 || op == 3'd2)) busy_until = cyc + MULT_N - 1;
        else if (iss && (op == 3'd3 || op == 3'd4)) busy_until = cyc + DIV_N - 1;
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic du);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, du, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        cyc = 0;
        model_reset();
        reset = 1'b1;
        {d_md_use, e_md_op, e_valid, pipe_hold, exc_flush, md_busy} = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cnt", 32'(dut.u_shadow.cnt), 32'd0);
        chk("rst_mop", 32'(dut.m_op_q), 32'd0);
        chk("rst_mism", 32'(busy_mismatch), 32'd0);
        reset = 1'b0;

        // mult issue with an MD op waiting in D: stalled for exactly 5 cycles
        stall_seen = 0;
        step(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(7, 1'b1);
        chk("mult_stall_len", 32'(stall_seen), 32'd5);

        // divu then mflo: 10 stalled cycles
        stall_seen = 0;
        step(1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(12, 1'b1);
        chk("divu_stall_len", 32'(stall_seen), 32'd10);

        // exception one cycle after mult issue cancels it
        step(1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);

        // exception after mthi rolls HI/LO back
        step(1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b0);

        // exception with div in E: never issued
        step(1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);

        // pipe_hold blocks multu until released; it then issues once
        for (int i = 0; i < 3; i++) step(1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(6, 1'b0);

        // flush while M holds no MD op leaves a div countdown alone
        step(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(10, 1'b1);

        // unit Busy diverging from the shadow sets a sticky flag
        step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(6, 1'b0);

        // async reset mid-div clears state before the next edge
        step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b1);
        e_valid = 1'b0; e_md_op = 3'd0; d_md_use = 1'b1; md_busy = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_stall", 32'(stall_d), 32'd0);
        chk("rst_mid_cnt", 32'(dut.u_shadow.cnt), 32'd0);
        chk("rst_mid_mism", 32'(busy_mismatch), 32'd0);
        md_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc++;
        model_reset();
        idle(2, 1'b1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic       v, du, h, f;
            logic [2:0] op;
            v  = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            du = $urandom_range(0, 1) == 1;
            h  = ($urandom_range(0, 7) == 0);
            f  = ($urandom_range(0, 11) == 0);
            step(v, op, du, h, f, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
Pipeline-side initiator for the multiply/divide unit. It sits between the E stage and the MD unit and drives the command code (`ALUMDctr` encoding) into the unit. It keeps a registered shadow of the unit's busy window so it can stall D-stage MD instructions. On an exception it sends the unit a cancel (break) or a HI/LO rollback (return), and it flags any divergence between its shadow and the unit's own Busy.

Parameters:
MULT_CYCLES, 5, total busy cycles of mult/multu, issue cycle included
DIV_CYCLES, 10, total busy cycles of div/divu, issue cycle included
CNT_W, 4, shadow counter width; must hold max(MULT_CYCLES,DIV_CYCLES)-1

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
d_md_use  in  1  instruction in D is mult/multu/div/divu/mtlo/mthi/mfhi/mflo
e_md_op  in  3  MD op of instruction in E: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mtlo, 6 mthi
e_valid  in  1  E holds a real (non-bubble) instruction
pipe_hold  in  1  whole pipeline frozen this cycle (e.g. memory stall); no issue, M shadow holds
exc_flush  in  1  exception/interrupt taken this cycle; the instruction in M and everything younger are killed
md_busy  in  1  Busy from MD unit
md_ctr  out  3  command to MD unit, same encoding as e_md_op
break_md  out  1  cancel in-flight mult/div in unit
return_lohi  out  1  restore previous HI/LO in unit
stall_d  out  1  hold D stage, insert bubble into E
busy_mismatch  out  1  sticky error: shadow busy disagreed with md_busy

Behaviour:
- Reset values: shadow_cnt=0, m_op_q=0, busy_mismatch=0.
- Combinational outputs: md_ctr, break_md, return_lohi, stall_d. The MD unit samples them on the same edge.
- issue = e_valid & ~pipe_hold & ~exc_flush & (e_md_op in 1..6).
- md_ctr = issue ? e_md_op : 0.
  - exc_flush kills the E op: it is never issued.
- m_op_q: registered copy of the op that reached the unit.
  - On each edge with ~pipe_hold: m_op_q <= issue ? e_md_op : 0.
  - Holds while pipe_hold is high.
  - Cleared on any edge where exc_flush is high.
- Exception response, when exc_flush=1:
  - m_op_q in 1..4 -> break_md=1 for that cycle.
  - m_op_q in 5..6 -> return_lohi=1 for that cycle.
  - Otherwise both stay 0.
  - break_md and return_lohi are never high together.
- Shadow counter, priority order per edge:
  1. break_md -> shadow_cnt <= 0.
  2. Else issue of mult/multu -> load MULT_CYCLES-1.
  3. Else issue of div/divu -> load DIV_CYCLES-1.
  4. Else shadow_cnt != 0 -> decrement. Decrement ignores pipe_hold, because the unit counts freely.
- shadow_busy = (shadow_cnt != 0) | (issue & e_md_op in 1..4). This matches the unit's Busy exactly, issue cycle included.
- stall_d = d_md_use & shadow_busy.
  - This covers all MD instructions, including mtlo/mthi/mfhi/mflo.
  - No second MD op can enter E while the unit counts down.
- A mult/div in E that completes issue is not stalled. An MD op in D behind it is stalled from the issue cycle through the last busy cycle.
- busy_mismatch: set on any edge where ~reset & (md_busy != shadow_busy). Sticky until reset.
- Reset mid-operation: all state clears asynchronously and outputs fall in the same cycle. The bench also resets the unit.
- An exc_flush that arrives while the op in M is not an MD op does not disturb an in-flight countdown. The result still lands in HI/LO.

Decomposition:
- Shared package mips_md_pkg, holding:
  - MD op code constants MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTLO=5, MD_MTHI=6;
  - helper predicates is_muldiv(op) and is_mt(op).
- MD unit and decoder import the same constants.
- One natural sub-module: md_busy_shadow (shadow counter + shadow_busy + mismatch flag). Issue/exception logic stays in the top.

Test Plan:
- mult issue: e_md_op=1, e_valid=1, d_md_use=1 held -> md_ctr=1 for one cycle; stall_d=1 for exactly 5 cycles; md_busy tracks; busy_mismatch stays 0.
- divu issue followed by mflo in D -> stall_d=1 for 10 cycles, 0 on cycle 11; shadow_cnt sequence 9..1 then 0.
- exc_flush the cycle after mult issue (m_op_q=1) -> break_md=1 for one cycle; shadow_cnt=0 next cycle; stall_d drops to 0 next cycle.
- mthi issued, exc_flush next cycle -> return_lohi=1, break_md=0; m_op_q=0 afterwards.
- exc_flush with e_md_op=3 in E -> md_ctr=0, no countdown started, stall_d=0.
- pipe_hold=1 with e_md_op=2 -> md_ctr=0 until hold released, then issues once. Separately, force md_busy=0 during a countdown -> busy_mismatch=1 and stays until reset. Asserting reset mid-div clears shadow_cnt and stall_d immediately, before the next clock edge.
